// File: rtl/tile_grid_ctrl_if.sv
// Signal bundle between tile_grid_ctrl and its users: pixel lookup, level load and tile clear.
interface tile_grid_ctrl_if;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        loadReq;
    logic [1:0]  levelSel;
    logic        clearReq;
    logic [2:0]  clearCol;
    logic [2:0]  clearRow;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic [1:0]  Tile_type;
    logic        clearAck;
    logic        busy;
    logic [5:0]  giftsLeft;
    logic        levelDone;

    modport master (
        output pixelX, pixelY, loadReq, levelSel, clearReq, clearCol, clearRow,
        input  offsetX, offsetY, Tile_type, clearAck, busy, giftsLeft, levelDone
    );

    modport slave (
        input  pixelX, pixelY, loadReq, levelSel, clearReq, clearCol, clearRow,
        output offsetX, offsetY, Tile_type, clearAck, busy, giftsLeft, levelDone
    );
endinterface

// File: rtl/tile_grid_ctrl.sv
// Maps VGA pixels to tile type and in-tile offset over an 8x6 flip-flop level grid,
// and owns level loading from ROM, gift clearing and the remaining-gift count.
module tile_grid_ctrl #(
    parameter int TILE_SIZE = 80,
    parameter int GRID_COLS = 8,
    parameter int GRID_ROWS = 6
) (
    input logic             clk,
    input logic             resetN,
    tile_grid_ctrl_if.slave bus
);
    localparam int          CELLS    = GRID_COLS * GRID_ROWS;
    localparam int          IDX_W    = $clog2(CELLS);
    localparam logic [10:0] X_LIMIT  = 11'(GRID_COLS * TILE_SIZE);
    localparam logic [10:0] Y_LIMIT  = 11'(GRID_ROWS * TILE_SIZE);
    localparam logic [5:0]  GIFT_MAX = 6'(CELLS);

    localparam logic [1:0] BG = 2'b00;
    localparam logic [1:0] FL = 2'b01;
    localparam logic [1:0] GF = 2'b10;
    localparam logic [1:0] HO = 2'b11;

    // One row of eight tiles per line; the bottom row of every level is solid floor.
    localparam logic [1:0] LEVEL_ROM [4][48] = '{
        '{BG, FL, FL, GF, FL, FL, FL, BG,
          FL, FL, FL, GF, FL, HO, FL, FL,
          FL, GF, FL, FL, FL, FL, GF, FL,
          FL, FL, HO, FL, FL, FL, FL, FL,
          FL, FL, FL, FL, GF, FL, FL, FL,
          FL, FL, FL, FL, FL, FL, FL, FL},
        '{FL, FL, FL, FL, FL, FL, FL, FL,
          GF, FL, FL, FL, FL, FL, FL, GF,
          FL, FL, HO, HO, HO, FL, FL, FL,
          FL, GF, FL, FL, FL, FL, GF, FL,
          BG, BG, FL, FL, FL, FL, BG, BG,
          FL, FL, FL, FL, FL, FL, FL, FL},
        '{GF, GF, GF, GF, GF, GF, GF, GF,
          FL, FL, FL, FL, FL, FL, FL, FL,
          FL, FL, FL, FL, FL, FL, FL, FL,
          FL, FL, FL, FL, HO, FL, FL, FL,
          FL, FL, FL, FL, FL, FL, FL, FL,
          FL, FL, FL, FL, FL, FL, FL, FL},
        '{FL, HO, FL, HO, FL, HO, FL, HO,
          FL, FL, FL, FL, FL, FL, FL, FL,
          BG, BG, BG, BG, BG, BG, BG, BG,
          FL, FL, FL, FL, FL, FL, FL, FL,
          HO, FL, FL, FL, FL, FL, FL, HO,
          FL, FL, FL, FL, FL, FL, FL, FL}
    };

    typedef enum logic [1:0] {BOOT, IDLE, LOAD, CLEAR} state_t;

    state_t             state_q, state_d;
    logic [1:0]         level_q, level_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic [5:0]         gifts_q, gifts_d;
    logic [1:0]         grid_q [CELLS];
    logic [1:0]         grid_d [CELLS];
    logic               clearAck_q, clearAck_d;
    logic [10:0]        offsetX_q, offsetX_d;
    logic [10:0]        offsetY_q, offsetY_d;
    logic [1:0]         tileType_q, tileType_d;

    logic [1:0]         romEntry;
    logic [IDX_W-1:0]   clearIdx;
    logic               clearInRange;
    logic [IDX_W-1:0]   lookIdx;
    logic               inField;
    logic [10:0]        baseX, baseY;
    int                 lookCol, lookRow;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // A held clearReq is not re-served in the cycle its acknowledge is visible.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:  state_d = LOAD;
            IDLE: begin
                if (bus.loadReq) begin
                    state_d = LOAD;
                end else if (bus.clearReq && !clearAck_q) begin
                    state_d = CLEAR;
                end
            end
            LOAD: begin
                if (index_q == IDX_W'(CELLS - 1)) begin
                    state_d = IDLE;
                end
            end
            CLEAR: state_d = IDLE;
            default: state_d = BOOT;
        endcase
    end

    assign romEntry     = LEVEL_ROM[level_q][index_q];
    assign clearInRange = (int'(bus.clearCol) < GRID_COLS) && (int'(bus.clearRow) < GRID_ROWS);
    assign clearIdx     = IDX_W'(int'(bus.clearRow) * GRID_COLS + int'(bus.clearCol));

    always_comb begin
        level_d    = level_q;
        index_d    = index_q;
        gifts_d    = gifts_q;
        grid_d     = grid_q;
        clearAck_d = 1'b0;
        case (state_q)
            BOOT: begin
                level_d = 2'd0;
                index_d = '0;
                gifts_d = '0;
            end
            IDLE: begin
                if (bus.loadReq) begin
                    level_d = bus.levelSel;
                    index_d = '0;
                    gifts_d = '0;
                end
            end
            LOAD: begin
                grid_d[index_q] = romEntry;
                if (romEntry == GF && gifts_q < GIFT_MAX) begin
                    gifts_d = gifts_q + 6'd1;
                end
                index_d = (index_q == IDX_W'(CELLS - 1)) ? '0 : index_q + IDX_W'(1);
            end
            CLEAR: begin
                clearAck_d = 1'b1;
                if (clearInRange && grid_q[clearIdx] == GF) begin
                    grid_d[clearIdx] = BG;
                    if (gifts_q != 6'd0) begin
                        gifts_d = gifts_q - 6'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Comparator chain: the highest tile boundary not above the pixel gives tile and base.
    always_comb begin
        lookCol = 0;
        lookRow = 0;
        baseX   = '0;
        baseY   = '0;
        for (int k = 1; k < GRID_COLS; k++) begin
            if (bus.pixelX >= 11'(k * TILE_SIZE)) begin
                lookCol = k;
                baseX   = 11'(k * TILE_SIZE);
            end
        end
        for (int k = 1; k < GRID_ROWS; k++) begin
            if (bus.pixelY >= 11'(k * TILE_SIZE)) begin
                lookRow = k;
                baseY   = 11'(k * TILE_SIZE);
            end
        end
    end

    assign lookIdx = IDX_W'(lookRow * GRID_COLS + lookCol);
    assign inField = (bus.pixelX < X_LIMIT) && (bus.pixelY < Y_LIMIT);

    // Lookup reads grid_d so a tile cleared this cycle already shows as background.
    always_comb begin
        offsetX_d  = inField ? bus.pixelX - baseX : 11'd0;
        offsetY_d  = inField ? bus.pixelY - baseY : 11'd0;
        tileType_d = (inField && state_q != LOAD) ? grid_d[lookIdx] : BG;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            level_q    <= '0;
            index_q    <= '0;
            gifts_q    <= '0;
            grid_q     <= '{default: BG};
            clearAck_q <= 1'b0;
            offsetX_q  <= '0;
            offsetY_q  <= '0;
            tileType_q <= BG;
        end else begin
            level_q    <= level_d;
            index_q    <= index_d;
            gifts_q    <= gifts_d;
            grid_q     <= grid_d;
            clearAck_q <= clearAck_d;
            offsetX_q  <= offsetX_d;
            offsetY_q  <= offsetY_d;
            tileType_q <= tileType_d;
        end
    end

    assign bus.offsetX   = offsetX_q;
    assign bus.offsetY   = offsetY_q;
    assign bus.Tile_type = tileType_q;
    assign bus.clearAck  = clearAck_q;
    assign bus.busy      = (state_q == LOAD);
    assign bus.giftsLeft = gifts_q;
    assign bus.levelDone = (state_q != LOAD) && (gifts_q == 6'd0);
endmodule

// File: tb/tb_tile_grid_ctrl.sv
// Directed bench for tile_grid_ctrl: boot load, pixel mapping, gift clearing,
// load/clear priority, reset during load and level completion.
module tb_tile_grid_ctrl;
    logic clk = 1'b0;
    logic resetN;
    int   checkCount = 0;
    int   errorCount = 0;
    int   busyLen;
    int   waitLen;
    int   modelGifts;
    logic [1:0] modelGrid [48];

    // Hand transcription of the level ROM: B background, F floor, G gift, H hole.
    string levelRows [24] = '{
        "BFFGFFFB", "FFFGFHFF", "FGFFFFGF", "FFHFFFFF", "FFFFGFFF", "FFFFFFFF",
        "FFFFFFFF", "GFFFFFFG", "FFHHHFFF", "FGFFFFGF", "BBFFFFBB", "FFFFFFFF",
        "GGGGGGGG", "FFFFFFFF", "FFFFFFFF", "FFFFHFFF", "FFFFFFFF", "FFFFFFFF",
        "FHFHFHFH", "FFFFFFFF", "BBBBBBBB", "FFFFFFFF", "HFFFFFFH", "FFFFFFFF"
    };

    tile_grid_ctrl_if bus();

    tile_grid_ctrl #(.TILE_SIZE(80), .GRID_COLS(8), .GRID_ROWS(6)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int x, input int y);
        bus.pixelX = 11'(x);
        bus.pixelY = 11'(y);
        waitCycle();
    endtask

    task automatic loadModel(input int lvl);
        string s;
        byte   ch;
        modelGifts = 0;
        for (int r = 0; r < 6; r++) begin
            s = levelRows[lvl * 6 + r];
            for (int c = 0; c < 8; c++) begin
                ch = s[c];
                case (ch)
                    "F":     modelGrid[r * 8 + c] = 2'b01;
                    "G":     modelGrid[r * 8 + c] = 2'b10;
                    "H":     modelGrid[r * 8 + c] = 2'b11;
                    default: modelGrid[r * 8 + c] = 2'b00;
                endcase
                if (ch == "G") modelGifts++;
            end
        end
    endtask

    task automatic checkTile(input int c, input int r);
        applyStimulus(c * 80 + 40, r * 80 + 40);
        checkOutput($sformatf("tile%0d_%0d", c, r), bus.Tile_type, modelGrid[r * 8 + c]);
    endtask

    task automatic scanGrid();
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 8; c++) begin
                checkTile(c, r);
            end
        end
    endtask

    task automatic measureBusy(output int n);
        n = 0;
        while (bus.busy && n < 200) begin
            n++;
            waitCycle();
        end
    endtask

    // Acknowledge must appear exactly two samples after the request is driven, for one cycle.
    task automatic doClear(input int c, input int r);
        bus.clearCol = 3'(c);
        bus.clearRow = 3'(r);
        bus.clearReq = 1'b1;
        waitCycle();
        checkOutput("ackEarly", bus.clearAck, 0);
        waitCycle();
        checkOutput("ackPulse", bus.clearAck, 1);
        bus.clearReq = 1'b0;
        if (r < 6 && c < 8) begin
            if (modelGrid[r * 8 + c] == 2'b10) begin
                modelGrid[r * 8 + c] = 2'b00;
                modelGifts--;
            end
        end
        waitCycle();
        checkOutput("ackLow", bus.clearAck, 0);
        checkOutput("clearGifts", bus.giftsLeft, modelGifts);
    endtask

    initial begin
        resetN       = 1'b0;
        bus.pixelX   = '0;
        bus.pixelY   = '0;
        bus.loadReq  = 1'b0;
        bus.levelSel = '0;
        bus.clearReq = 1'b0;
        bus.clearCol = '0;
        bus.clearRow = '0;
        repeat (3) @(posedge clk);
        #1;
        $display("[TB] reset state");
        checkOutput("rstOffX", bus.offsetX, 0);
        checkOutput("rstOffY", bus.offsetY, 0);
        checkOutput("rstType", bus.Tile_type, 0);
        checkOutput("rstAck", bus.clearAck, 0);
        checkOutput("rstGifts", bus.giftsLeft, 0);
        checkOutput("rstBusy", bus.busy, 0);

        $display("[TB] boot load of level 0");
        @(negedge clk);
        resetN = 1'b1;
        waitCycle();
        measureBusy(busyLen);
        checkOutput("bootBusyLen", busyLen, 48);
        loadModel(0);
        checkOutput("bootGifts", bus.giftsLeft, 5);
        checkOutput("bootGiftsModel", bus.giftsLeft, modelGifts);
        checkOutput("bootDone", bus.levelDone, 0);
        scanGrid();

        $display("[TB] pixel mapping");
        applyStimulus(85, 170);
        checkOutput("mapOffX", bus.offsetX, 5);
        checkOutput("mapOffY", bus.offsetY, 10);
        checkOutput("mapType", bus.Tile_type, 2);
        applyStimulus(640, 0);
        checkOutput("outXOffX", bus.offsetX, 0);
        checkOutput("outXOffY", bus.offsetY, 0);
        checkOutput("outXType", bus.Tile_type, 0);
        applyStimulus(639, 479);
        checkOutput("edgeOffX", bus.offsetX, 79);
        checkOutput("edgeOffY", bus.offsetY, 79);
        checkOutput("edgeType", bus.Tile_type, 1);
        applyStimulus(100, 480);
        checkOutput("outYOffX", bus.offsetX, 0);
        checkOutput("outYType", bus.Tile_type, 0);

        $display("[TB] clearing tiles");
        doClear(3, 1);
        checkOutput("giftCleared", bus.giftsLeft, 4);
        applyStimulus(245, 85);
        checkOutput("clrType", bus.Tile_type, 0);
        checkOutput("clrOffX", bus.offsetX, 5);
        checkOutput("clrOffY", bus.offsetY, 5);
        doClear(0, 1);
        checkOutput("floorKept", bus.giftsLeft, 4);
        checkTile(0, 1);
        doClear(7, 6);
        checkOutput("rangeKept", bus.giftsLeft, 4);

        $display("[TB] load and clear in the same cycle");
        bus.levelSel = 2'd1;
        bus.loadReq  = 1'b1;
        bus.clearCol = 3'd0;
        bus.clearRow = 3'd1;
        bus.clearReq = 1'b1;
        waitCycle();
        bus.loadReq = 1'b0;
        checkOutput("lcBusy", bus.busy, 1);
        waitLen = 0;
        while (!bus.clearAck && waitLen < 200) begin
            waitLen++;
            waitCycle();
        end
        checkOutput("lcAckLatency", waitLen, 50);
        bus.clearReq = 1'b0;
        loadModel(1);
        modelGrid[8] = 2'b00;
        modelGifts--;
        waitCycle();
        checkOutput("lcAckLow", bus.clearAck, 0);
        checkOutput("lcGifts", bus.giftsLeft, 3);
        checkOutput("lcGiftsModel", bus.giftsLeft, modelGifts);
        scanGrid();

        $display("[TB] reset during load");
        bus.pixelX   = 11'd85;
        bus.pixelY   = 11'd170;
        bus.levelSel = 2'd2;
        bus.loadReq  = 1'b1;
        waitCycle();
        bus.loadReq = 1'b0;
        repeat (19) waitCycle();
        checkOutput("midBusy", bus.busy, 1);
        checkOutput("midOffX", bus.offsetX, 5);
        checkOutput("midOffY", bus.offsetY, 10);
        checkOutput("midType", bus.Tile_type, 0);
        checkOutput("midGifts", bus.giftsLeft, 8);
        #1;
        resetN = 1'b0;
        #1;
        checkOutput("abortOffX", bus.offsetX, 0);
        checkOutput("abortOffY", bus.offsetY, 0);
        checkOutput("abortType", bus.Tile_type, 0);
        checkOutput("abortGifts", bus.giftsLeft, 0);
        checkOutput("abortBusy", bus.busy, 0);
        checkOutput("abortAck", bus.clearAck, 0);
        @(negedge clk);
        resetN = 1'b1;
        waitCycle();
        measureBusy(busyLen);
        checkOutput("reloadBusyLen", busyLen, 48);
        loadModel(0);
        checkOutput("reloadGifts", bus.giftsLeft, 5);
        scanGrid();

        $display("[TB] clearing every gift");
        checkOutput("doneBefore", bus.levelDone, 0);
        for (int idx = 0; idx < 48; idx++) begin
            if (modelGrid[idx] == 2'b10) doClear(idx % 8, idx / 8);
        end
        checkOutput("allGiftsGone", bus.giftsLeft, 0);
        checkOutput("doneAfter", bus.levelDone, 1);
        doClear(3, 1);
        checkOutput("giftsFloor", bus.giftsLeft, 0);

        $display("[TB] level without gifts");
        bus.levelSel = 2'd3;
        bus.loadReq  = 1'b1;
        waitCycle();
        bus.loadReq = 1'b0;
        checkOutput("lvl3DoneWhileBusy", bus.levelDone, 0);
        measureBusy(busyLen);
        checkOutput("lvl3BusyLen", busyLen, 48);
        loadModel(3);
        checkOutput("lvl3Gifts", bus.giftsLeft, 0);
        checkOutput("lvl3Done", bus.levelDone, 1);
        checkTile(1, 0);
        checkTile(0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule

// File: doc/tile_grid_ctrl.md
# tile_grid_ctrl

Upstream stage of the tile renderer: converts the VGA pixel coordinate into a tile index plus in-tile offset and looks up the tile type in an on-chip 8×6 level grid. It feeds offsetX, offsetY and Tile_type to the tile drawing block. It also owns the level content: it loads a level from an internal ROM, clears gift tiles on request from game logic and counts remaining gifts.

## Interface
Parameters:
- TILE_SIZE, 80, tile edge in pixels; supported values are 80 and 64 only
- GRID_COLS, 8, tiles per row
- GRID_ROWS, 6, tile rows

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous, active-low reset
- pixelX  in  11  current VGA pixel column
- pixelY  in  11  current VGA pixel row
- loadReq  in  1  one-cycle pulse: load level `levelSel`
- levelSel  in  2  level number 0..3
- clearReq  in  1  request to turn tile (clearCol, clearRow) into background; held until clearAck
- clearCol  in  3  column of tile to clear
- clearRow  in  3  row of tile to clear
- offsetX  out  11  pixel offset inside tile, registered
- offsetY  out  11  pixel offset inside tile, registered
- Tile_type  out  2  00 background, 01 floor, 10 gift, 11 hole; registered
- clearAck  out  1  one-cycle pulse when a clear was applied or rejected
- busy  out  1  high while loading
- giftsLeft  out  6  gift tiles remaining in grid
- levelDone  out  1  high when not busy and giftsLeft == 0

## Operation
- Grid storage: 48 entries × 2 bits, index = row*8 + col. Storage is flip-flops, not block RAM.
- Level ROM: constant table, 4 levels × 48 entries. Row 5 of every level is all floor (01).
- Coordinate mapping:
  - col = number of thresholds k*TILE_SIZE (k = 1..7) with pixelX ≥ threshold. Computed by comparator chain; no divider.
  - row is computed the same way from pixelY.
  - offsetX = pixelX − col*TILE_SIZE; offsetY = pixelY − row*TILE_SIZE.
- Out of field: if pixelX ≥ GRID_COLS*TILE_SIZE or pixelY ≥ GRID_ROWS*TILE_SIZE, then Tile_type = 00 and offsets = 0.
- FSM states:
  - IDLE: if loadReq, latch levelSel, set index 0, clear giftsLeft, go to LOAD. Otherwise, if clearReq is pending, go to CLEAR.
  - LOAD: each cycle copy ROM[level][index] to grid[index]. Increment giftsLeft if the entry is 10. Increment index. After index 47, go to IDLE. Duration is exactly 48 cycles.
  - CLEAR: one cycle.
    - If grid[clearRow*8 + clearCol] == 10, write 00 and decrement giftsLeft.
    - Otherwise, including out-of-range col ≥ 8 or row ≥ 6, leave the grid unchanged.
    - Pulse clearAck in either case, then return to IDLE.
- Priority in IDLE: loadReq wins over clearReq. A pending clearReq waits and is served after the load.
- loadReq is ignored while in LOAD or CLEAR; it is not queued.
- busy = (state == LOAD). While busy, Tile_type output is forced to 00 and offsets are still computed.
- giftsLeft saturates: it never goes below 0 or above 48.

## Timing
- Display path latency is 1 cycle. Registered offsets and Tile_type correspond to the pixelX/pixelY of the previous clock edge.
- Lookup reads the grid through the same-cycle write path: a tile cleared on cycle N shows 00 from the pixel sampled at cycle N+1.
- clearAck goes high in the cycle after the CLEAR state is entered: 2 cycles after clearReq is sampled in IDLE.
- After the loadReq edge, busy is high for 48 cycles. levelDone may rise the cycle after busy falls.
- Reset (asynchronous): outputs take the following values.
  - offsetX/offsetY = 0, Tile_type = 00, clearAck = 0, giftsLeft = 0.
  - Grid = all 00.
  - FSM enters LOAD of level 0 at the first clock after release, so busy = 1 from the first clock after reset release.
- resetN asserted mid-LOAD or mid-CLEAR aborts immediately and applies the reset values. No partial level survives.

## Test plan
- Reset release, no requests → busy high for exactly 48 cycles. After that, grid equals ROM level 0 and giftsLeft equals the count of 10 entries in level 0.
- Pixel (85, 170) with TILE_SIZE 80 → after 1 cycle, offsetX = 5, offsetY = 10, Tile_type = grid[2*8+1]. Pixel (640, 0) → Tile_type = 00, offsets 0.
- clearReq on a known gift tile (col 3, row 1) → clearAck pulse 2 cycles later, giftsLeft decremented by 1, and the next lookup of pixel (245, 85) returns 00.
- clearReq on a floor tile and on col 7, row 6 → clearAck pulses, grid and giftsLeft unchanged.
- loadReq and clearReq in the same cycle in IDLE → level loads first (48 cycles), then the clear is applied against the new level.
- resetN pulsed low at LOAD cycle 20 → all outputs reset immediately, then a full 48-cycle reload of level 0. Clearing all gifts one by one → levelDone = 1 once giftsLeft = 0.
